// File: rtl/minterm_sweep_checker.sv
// minterm_sweep_checker
// Sweeps all 16 combinations of {A,B,C,D} into the 4-input function block,
// holds each one for SETTLE_CYC cycles, samples func_o and compares it with
// the TRUTH table. Reports mismatch count, per-minterm fail mask and the
// first failing index.
//
// Build option: define STOP_ON_FAIL_EN to abort the sweep at the first
// mismatching index (idx then holds the failing index).
module minterm_sweep_checker #(
    parameter logic [15:0] TRUTH      = 16'hA5F5,
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        func_o,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    output logic        busy,
    output logic        done,
    output logic [4:0]  err_cnt,
    output logic [15:0] fail_mask,
    output logic [3:0]  first_fail,
    output logic        fail_seen
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Last value of the wait counter before moving on to CHECK.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  wait_q, wait_d;
    logic [4:0]  err_q, err_d;
    logic [15:0] mask_q, mask_d;
    logic [3:0]  first_q, first_d;
    logic        seen_q, seen_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        mismatch_s;

    // Next-state and result update logic for the sweep FSM.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wait_d     = wait_q;
        err_d      = err_q;
        mask_d     = mask_q;
        first_d    = first_q;
        seen_d     = seen_q;
        mismatch_s = (func_o != TRUTH[idx_q]);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d   = 5'd0;
                    mask_d  = 16'h0000;
                    first_d = 4'd0;
                    seen_d  = 1'b0;
                    idx_d   = 4'd0;
                    wait_d  = 4'd0;
                    state_d = S_SETTLE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (wait_q == SETTLE_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_CHECK: begin
                if (mismatch_s) begin
                    // At most 16 checks per sweep, so the 5-bit count never wraps.
                    err_d         = err_q + 5'd1;
                    mask_d[idx_q] = 1'b1;
                    if (!seen_q) begin
                        first_d = idx_q;
                        seen_d  = 1'b1;
                    end else begin
                        first_d = first_q;
                    end
                end else begin
                    err_d = err_q;
                end
`ifdef STOP_ON_FAIL_EN
                if (mismatch_s || (idx_q == 4'd15)) begin
`else
                if (idx_q == 4'd15) begin
`endif
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    wait_d  = 4'd0;
                    state_d = S_SETTLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flags are registered from the next state so they line up
        // with the state they describe.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State, stimulus index and result registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
            wait_q  <= 4'd0;
            err_q   <= 5'd0;
            mask_q  <= 16'h0000;
            first_q <= 4'd0;
            seen_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
            first_q <= first_d;
            seen_q  <= seen_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign {A, B, C, D} = idx_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_cnt      = err_q;
    assign fail_mask    = mask_q;
    assign first_fail   = first_q;
    assign fail_seen    = seen_q;

endmodule

// File: tb/tb_minterm_sweep_checker.sv
// Testbench for minterm_sweep_checker: table of faulty function models with
// hand-computed sweep results, plus re-pulsed start and mid-sweep reset.
module tb_minterm_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start;
    logic f0, f1;
    logic a0, b0, c0, d0, busy0, done0, seen0;
    logic a1, b1, c1, d1, busy1, done1, seen1;
    logic [4:0]  err0, err1;
    logic [15:0] mask0, mask1;
    logic [3:0]  first0, first1;

    int          mode;
    logic [15:0] inv;
    logic [15:0] truth_v;
    int          sel;
    int          checks;
    int          fails;

    logic        obs_busy, obs_done, obs_seen;
    logic [3:0]  obs_idx, obs_first;
    logic [4:0]  obs_err;
    logic [15:0] obs_mask;

    minterm_sweep_checker dut0 (
        .clk(clk), .rst(rst), .start(start), .func_o(f0),
        .A(a0), .B(b0), .C(c0), .D(d0), .busy(busy0), .done(done0),
        .err_cnt(err0), .fail_mask(mask0), .first_fail(first0), .fail_seen(seen0)
    );

    minterm_sweep_checker #(.SETTLE_CYC(3)) dut1 (
        .clk(clk), .rst(rst), .start(start), .func_o(f1),
        .A(a1), .B(b1), .C(c1), .D(d1), .busy(busy1), .done(done1),
        .err_cnt(err1), .fail_mask(mask1), .first_fail(first1), .fail_seen(seen1)
    );

    // Function block model: 1 = stuck at 0, 2 = stuck at 1, else truth xor inv.
    function automatic logic fmodel(input int m, input logic [15:0] t,
                                    input logic [15:0] iv, input logic [3:0] i);
        case (m)
            1:       return 1'b0;
            2:       return 1'b1;
            default: return t[i] ^ iv[i];
        endcase
    endfunction

    always_comb begin
        f0 = fmodel(mode, truth_v, inv, {a0, b0, c0, d0});
        f1 = fmodel(mode, truth_v, inv, {a1, b1, c1, d1});
    end

    always_comb begin
        if (sel == 1) begin
            obs_busy = busy1; obs_done = done1; obs_seen = seen1;
            obs_idx = {a1, b1, c1, d1}; obs_first = first1;
            obs_err = err1; obs_mask = mask1;
        end else begin
            obs_busy = busy0; obs_done = done0; obs_seen = seen0;
            obs_idx = {a0, b0, c0, d0}; obs_first = first0;
            obs_err = err0; obs_mask = mask0;
        end
    end

    typedef struct {
        string       name;
        int          sel;
        int          mode;
        logic [15:0] inv;
        int          lat;
        logic [4:0]  err;
        logic [15:0] mask;
        logic [3:0]  first;
        logic        seen;
        logic [3:0]  end_idx;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One sweep: start, track idx/busy every cycle, measure done latency,
    // check results at the done cycle. repulse_at >= 0 re-pulses start.
    task automatic run_vec(input vec_t v, input int repulse_at);
        int n, got, spv, tail;
        bit seq_ok;
        sel  = v.sel;
        mode = v.mode;
        inv  = v.inv;
        spv  = (v.sel == 1) ? 4 : 2;
        n = 0;
        while ((busy0 || busy1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({v.name, " idle_before"}, {31'd0, busy0 | busy1}, 32'd0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        got = -1;
        seq_ok = 1'b1;
        n = 0;
        while (got < 0 && n <= v.lat + 8) begin
            if (obs_done === 1'b1) begin
                got = n;
            end else begin
                if (obs_busy !== 1'b1) seq_ok = 1'b0;
                if (n < v.lat && obs_idx !== 4'(n / spv)) seq_ok = 1'b0;
                if (n == repulse_at) start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
                n++;
            end
        end
        chk({v.name, " latency"}, got, v.lat);
        chk({v.name, " err_cnt"}, {27'd0, obs_err}, {27'd0, v.err});
        chk({v.name, " fail_mask"}, {16'd0, obs_mask}, {16'd0, v.mask});
        chk({v.name, " first_fail"}, {28'd0, obs_first}, {28'd0, v.first});
        chk({v.name, " fail_seen"}, {31'd0, obs_seen}, {31'd0, v.seen});
        chk({v.name, " end_idx"}, {28'd0, obs_idx}, {28'd0, v.end_idx});
        if (obs_busy !== 1'b1) seq_ok = 1'b0;
        tail = (repulse_at >= 0) ? 40 : 1;
        for (int k = 1; k <= tail; k++) begin
            @(posedge clk);
            #1;
            if (obs_done !== 1'b0) seq_ok = 1'b0;
            if (k == 1 && obs_busy !== 1'b0) seq_ok = 1'b0;
        end
        chk({v.name, " sequence"}, {31'd0, seq_ok}, 32'd1);
        if (repulse_at >= 0) begin
            chk({v.name, " hold_err"}, {27'd0, obs_err}, {27'd0, v.err});
            chk({v.name, " hold_mask"}, {16'd0, obs_mask}, {16'd0, v.mask});
        end
    endtask

    vec_t rv;
    bit   quiet;

    initial begin
        checks  = 0;
        fails   = 0;
        truth_v = 16'hA5F5;
        mode    = 0;
        inv     = 16'h0000;
        sel     = 0;
        rst     = 1'b1;
        start   = 1'b0;

`ifdef STOP_ON_FAIL_EN
        vecs[0] = '{"correct",  0, 0, 16'h0000, 32, 5'd0, 16'h0000, 4'd0,  1'b0, 4'd15};
        vecs[1] = '{"stuck0",   0, 1, 16'h0000,  2, 5'd1, 16'h0001, 4'd0,  1'b1, 4'd0};
        vecs[2] = '{"stuck1",   0, 2, 16'h0000,  4, 5'd1, 16'h0002, 4'd1,  1'b1, 4'd1};
        vecs[3] = '{"inv13",    0, 0, 16'h2000, 28, 5'd1, 16'h2000, 4'd13, 1'b1, 4'd13};
        vecs[4] = '{"inv0_15",  0, 0, 16'h8001,  2, 5'd1, 16'h0001, 4'd0,  1'b1, 4'd0};
        vecs[5] = '{"inv4_7",   0, 0, 16'h00F0, 10, 5'd1, 16'h0010, 4'd4,  1'b1, 4'd4};
        vecs[6] = '{"inv_all",  0, 0, 16'hFFFF,  2, 5'd1, 16'h0001, 4'd0,  1'b1, 4'd0};
        vecs[7] = '{"inv15",    0, 0, 16'h8000, 32, 5'd1, 16'h8000, 4'd15, 1'b1, 4'd15};
        vecs[8] = '{"s3_inv13", 1, 0, 16'h2000, 56, 5'd1, 16'h2000, 4'd13, 1'b1, 4'd13};
`else
        vecs[0] = '{"correct",  0, 0, 16'h0000, 32, 5'd0,  16'h0000, 4'd0,  1'b0, 4'd15};
        vecs[1] = '{"stuck0",   0, 1, 16'h0000, 32, 5'd10, 16'hA5F5, 4'd0,  1'b1, 4'd15};
        vecs[2] = '{"stuck1",   0, 2, 16'h0000, 32, 5'd6,  16'h5A0A, 4'd1,  1'b1, 4'd15};
        vecs[3] = '{"inv13",    0, 0, 16'h2000, 32, 5'd1,  16'h2000, 4'd13, 1'b1, 4'd15};
        vecs[4] = '{"inv0_15",  0, 0, 16'h8001, 32, 5'd2,  16'h8001, 4'd0,  1'b1, 4'd15};
        vecs[5] = '{"inv4_7",   0, 0, 16'h00F0, 32, 5'd4,  16'h00F0, 4'd4,  1'b1, 4'd15};
        vecs[6] = '{"inv_all",  0, 0, 16'hFFFF, 32, 5'd16, 16'hFFFF, 4'd0,  1'b1, 4'd15};
        vecs[7] = '{"inv15",    0, 0, 16'h8000, 32, 5'd1,  16'h8000, 4'd15, 1'b1, 4'd15};
        vecs[8] = '{"s3_inv13", 1, 0, 16'h2000, 64, 5'd1,  16'h2000, 4'd13, 1'b1, 4'd15};
`endif

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_state",
            {a0, b0, c0, d0, busy0, done0, err0, mask0, first0, seen0}, 32'd0);

        foreach (vecs[i]) run_vec(vecs[i], -1);

        // start re-pulsed at cycle 10 must be ignored
        rv = '{"repulse", 0, 0, 16'h8000, 32, 5'd1, 16'h8000, 4'd15, 1'b1, 4'd15};
        run_vec(rv, 10);

        // asynchronous reset at cycle 15 of a sweep
        sel  = 0;
        mode = 0;
`ifdef STOP_ON_FAIL_EN
        inv = 16'h8000;
`else
        inv = 16'h0010;
`endif
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("pre_reset_busy", {31'd0, busy0}, 32'd1);
        chk("pre_reset_idx", {28'd0, a0, b0, c0, d0}, 32'd7);
`ifdef STOP_ON_FAIL_EN
        chk("pre_reset_err", {27'd0, err0}, 32'd0);
`else
        chk("pre_reset_err", {27'd0, err0}, 32'd1);
`endif
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset",
            {a0, b0, c0, d0, busy0, done0, err0, mask0, first0, seen0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        quiet = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done0 !== 1'b0 || busy0 !== 1'b0) quiet = 1'b0;
        end
        chk("no_done_after_reset", {31'd0, quiet}, 32'd1);
        run_vec(vecs[0], -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
